// File: rtl/stim_seq_pkg.sv
// stim_seq_pkg: shared state encoding, polarity codes and default widths
// for the stimulation pulse-train sequencer.
package stim_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        IPG,
        PH2,
        IBD,
        REC,
        ITD
    } state_e;

    localparam logic ANODIC   = 1'b1;
    localparam logic CATHODIC = 1'b0;

    typedef enum logic [1:0] {
        W_CHANNELS,
        W_CNT,
        W_MAG
    } width_sel_e;

    function automatic int default_width(width_sel_e sel);
        unique case (sel)
            W_CHANNELS: return 16;
            W_CNT:      return 16;
            W_MAG:      return 8;
            default:    return 16;
        endcase
    endfunction

endpackage

// File: rtl/stim_train_sequencer_if.sv
// stim_train_sequencer_if: per-channel drive bundle from the sequencer
// to the RHS command builder.
interface stim_train_sequencer_if #(
    parameter int CHANNELS = 16,
    parameter int MAG_W    = 8
);
    logic [CHANNELS-1:0] stim_en_mask;
    logic [CHANNELS-1:0] stim_pol_mask;
    logic [MAG_W-1:0]    stim_magnitude;
    logic [CHANNELS-1:0] recovery_en;

    modport master (
        output stim_en_mask,
        output stim_pol_mask,
        output stim_magnitude,
        output recovery_en
    );

    modport slave (
        input stim_en_mask,
        input stim_pol_mask,
        input stim_magnitude,
        input recovery_en
    );
endinterface

// File: rtl/stim_tick_counter.sv
// stim_tick_counter: loadable down-counter stepped by sample_tick,
// flagging the tick that brings it to zero.
module stim_tick_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             tick_i,
    output logic             zero_o,
    output logic             expire_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o   = (cnt_q == '0);
    assign expire_o = tick_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/stim_train_sequencer.sv
// stim_train_sequencer: biphasic stimulation pulse-train sequencer.
// Define STIM_ASYM_PHASE_EN for independent PH2 length and magnitude.
module stim_train_sequencer
    import stim_seq_pkg::*;
#(
    parameter int CHANNELS = default_width(W_CHANNELS),
    parameter int CNT_W    = default_width(W_CNT),
    parameter int MAG_W    = default_width(W_MAG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic                   finite_start,
    input  logic                   infinite_start,
    input  logic                   stop,
    input  logic [CNT_W-1:0]       cfg_pulse_len,
`ifdef STIM_ASYM_PHASE_EN
    input  logic [CNT_W-1:0]       cfg_pulse2_len,
    input  logic [MAG_W-1:0]       cfg_magnitude2,
`endif
    input  logic [CNT_W-1:0]       cfg_inter_pulse,
    input  logic [CNT_W-1:0]       cfg_inter_bipulse,
    input  logic [CNT_W-1:0]       cfg_inter_train,
    input  logic [CNT_W-1:0]       cfg_recovery,
    input  logic [CNT_W-1:0]       cfg_bipulses,
    input  logic [CNT_W-1:0]       cfg_trains,
    input  logic [MAG_W-1:0]       cfg_magnitude,
    input  logic                   cfg_rising_first,
    input  logic                   cfg_bipolar,
    input  logic [CHANNELS-1:0]    cfg_mask_pos,
    input  logic [CHANNELS-1:0]    cfg_mask_neg,
    stim_train_sequencer_if.master drv,
    output logic                   busy,
    output logic [CNT_W-1:0]       bipulse_idx,
    output logic [CNT_W-1:0]       train_idx,
    output logic                   train_done,
    output logic                   seq_done
);
    typedef struct packed {
        logic [CNT_W-1:0]    pl, pl2, ip, ibd, it, rec;
        logic [CNT_W-1:0]    nb_last, nt_last;
        logic [MAG_W-1:0]    mag, mag2;
        logic                rf, bip;
        logic [CHANNELS-1:0] pos, neg;
    } cfg_t;

    function automatic logic [CNT_W-1:0] min1(logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [CNT_W-1:0] dur_of(state_e s, cfg_t c);
        unique case (s)
            PH1:     return c.pl;
            IPG:     return c.ip;
            PH2:     return c.pl2;
            IBD:     return c.ibd;
            REC:     return c.rec;
            ITD:     return c.it;
            default: return '0;
        endcase
    endfunction

    state_e              state_q, state_d;
    cfg_t                cfg_q, cfg_d, cfg_new;
    logic                fin_q, fin_d;
    logic                stop_q, stop_d;
    logic [CNT_W-1:0]    bidx_q, bidx_d;
    logic [CNT_W-1:0]    tidx_q, tidx_d;
    logic                td_q, td_d;
    logic                sd_q, sd_d;
    logic                busy_q, busy_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] pol_q, pol_d;
    logic [CHANNELS-1:0] rec_en_q, rec_en_d;
    logic [MAG_W-1:0]    mag_q, mag_d;

    logic                start_ok;
    logic                cnt_zero, cnt_expire, exit_now;
    logic                to_rec, end_train;
    logic                pos_pol;
    logic [CHANNELS-1:0] pos_m, neg_m;

    stim_tick_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_d != state_q),
        .load_val_i (dur_of(state_d, cfg_d)),
        .tick_i     (sample_tick),
        .zero_o     (cnt_zero),
        .expire_o   (cnt_expire)
    );

    // A timed state never sits at zero; treat it as already expired.
    assign exit_now = cnt_expire | cnt_zero;
    assign start_ok = (finite_start | infinite_start) & ~stop;

    always_comb begin
        cfg_new         = cfg_q;
        cfg_new.pl      = min1(cfg_pulse_len);
        cfg_new.ip      = cfg_inter_pulse;
        cfg_new.ibd     = cfg_inter_bipulse;
        cfg_new.it      = cfg_inter_train;
        cfg_new.rec     = cfg_recovery;
        cfg_new.nb_last = min1(cfg_bipulses) - CNT_W'(1);
        cfg_new.nt_last = min1(cfg_trains) - CNT_W'(1);
        cfg_new.mag     = cfg_magnitude;
        cfg_new.rf      = cfg_rising_first;
        cfg_new.bip     = cfg_bipolar;
        cfg_new.pos     = cfg_mask_pos;
        cfg_new.neg     = cfg_mask_neg;
`ifdef STIM_ASYM_PHASE_EN
        cfg_new.pl2     = min1(cfg_pulse2_len);
        cfg_new.mag2    = cfg_magnitude2;
`else
        cfg_new.pl2     = min1(cfg_pulse_len);
        cfg_new.mag2    = cfg_magnitude;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        fin_d     = fin_q;
        stop_d    = stop_q;
        bidx_d    = bidx_q;
        tidx_d    = tidx_q;
        td_d      = 1'b0;
        sd_d      = 1'b0;
        to_rec    = 1'b0;
        end_train = 1'b0;

        if (state_q != IDLE && stop) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    cfg_d   = cfg_new;
                    fin_d   = finite_start;
                    stop_d  = 1'b0;
                    bidx_d  = '0;
                    tidx_d  = '0;
                    state_d = PH1;
                end
            end
            PH1: begin
                if (exit_now) begin
                    state_d = (cfg_q.ip == '0) ? PH2 : IPG;
                end
            end
            IPG: begin
                if (exit_now) begin
                    state_d = PH2;
                end
            end
            PH2: begin
                if (exit_now) begin
                    if (bidx_q == cfg_q.nb_last) begin
                        to_rec = 1'b1;
                    end else if (cfg_q.ibd == '0) begin
                        bidx_d  = bidx_q + CNT_W'(1);
                        state_d = PH1;
                    end else begin
                        state_d = IBD;
                    end
                end
            end
            IBD: begin
                if (exit_now) begin
                    bidx_d  = bidx_q + CNT_W'(1);
                    state_d = PH1;
                end
            end
            REC: begin
                end_train = exit_now;
            end
            ITD: begin
                if (exit_now) begin
                    bidx_d  = '0;
                    tidx_d  = tidx_q + CNT_W'(1);
                    state_d = PH1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero-length REC/ITD collapse into the PH2 exit cycle.
        if (to_rec) begin
            if (cfg_q.rec == '0) begin
                end_train = 1'b1;
            end else begin
                state_d = REC;
            end
        end

        if (end_train) begin
            td_d = 1'b1;
            if (stop_d || (fin_q && tidx_q == cfg_q.nt_last)) begin
                sd_d    = 1'b1;
                state_d = IDLE;
            end else if (cfg_q.it == '0) begin
                bidx_d  = '0;
                tidx_d  = tidx_q + CNT_W'(1);
                state_d = PH1;
            end else begin
                state_d = ITD;
            end
        end

        if (state_d == IDLE) begin
            stop_d = 1'b0;
        end
    end

    always_comb begin
        pos_m = cfg_d.pos;
        neg_m = cfg_d.bip ? (cfg_d.neg & ~cfg_d.pos) : '0;
        if (state_d == PH1) begin
            pos_pol = cfg_d.rf ? ANODIC : CATHODIC;
        end else begin
            pos_pol = cfg_d.rf ? CATHODIC : ANODIC;
        end

        en_d     = '0;
        pol_d    = '0;
        rec_en_d = '0;
        mag_d    = '0;
        busy_d   = (state_d != IDLE);

        if (state_d == PH1 || state_d == PH2) begin
            en_d  = pos_m | neg_m;
            pol_d = (pos_pol == ANODIC) ? pos_m : neg_m;
            mag_d = (state_d == PH1) ? cfg_d.mag : cfg_d.mag2;
        end
        if (state_d == REC) begin
            rec_en_d = pos_m | neg_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            fin_q    <= 1'b0;
            stop_q   <= 1'b0;
            bidx_q   <= '0;
            tidx_q   <= '0;
            td_q     <= 1'b0;
            sd_q     <= 1'b0;
            busy_q   <= 1'b0;
            en_q     <= '0;
            pol_q    <= '0;
            rec_en_q <= '0;
            mag_q    <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            fin_q    <= fin_d;
            stop_q   <= stop_d;
            bidx_q   <= bidx_d;
            tidx_q   <= tidx_d;
            td_q     <= td_d;
            sd_q     <= sd_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
            pol_q    <= pol_d;
            rec_en_q <= rec_en_d;
            mag_q    <= mag_d;
        end
    end

    assign drv.stim_en_mask   = en_q;
    assign drv.stim_pol_mask  = pol_q;
    assign drv.stim_magnitude = mag_q;
    assign drv.recovery_en    = rec_en_q;
    assign busy               = busy_q;
    assign bipulse_idx        = bidx_q;
    assign train_idx          = tidx_q;
    assign train_done         = td_q;
    assign seq_done           = sd_q;

endmodule

// File: tb/tb_stim_train_sequencer.sv
// tb_stim_train_sequencer: directed and randomized runs of the sequencer
// against a per-tick schedule built from the train rules.
module tb_stim_train_sequencer;
    localparam int CH = 16;
    localparam int CW = 16;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_tick = 1'b0;
    logic finite_start = 1'b0;
    logic infinite_start = 1'b0;
    logic stop = 1'b0;
    logic [CW-1:0] cfg_pulse_len = '0;
    logic [CW-1:0] cfg_inter_pulse = '0;
    logic [CW-1:0] cfg_inter_bipulse = '0;
    logic [CW-1:0] cfg_inter_train = '0;
    logic [CW-1:0] cfg_recovery = '0;
    logic [CW-1:0] cfg_bipulses = '0;
    logic [CW-1:0] cfg_trains = '0;
    logic [MW-1:0] cfg_magnitude = '0;
    logic cfg_rising_first = 1'b0;
    logic cfg_bipolar = 1'b0;
    logic [CH-1:0] cfg_mask_pos = '0;
    logic [CH-1:0] cfg_mask_neg = '0;
`ifdef STIM_ASYM_PHASE_EN
    logic [CW-1:0] cfg_pulse2_len = '0;
    logic [MW-1:0] cfg_magnitude2 = '0;
`endif
    logic busy, train_done, seq_done;
    logic [CW-1:0] bipulse_idx, train_idx;

    always #5 clk = ~clk;

    stim_train_sequencer_if #(.CHANNELS(CH), .MAG_W(MW)) drv_if ();

    stim_train_sequencer #(.CHANNELS(CH), .CNT_W(CW), .MAG_W(MW)) dut (
        .clk               (clk),
        .rst               (rst),
        .sample_tick       (sample_tick),
        .finite_start      (finite_start),
        .infinite_start    (infinite_start),
        .stop              (stop),
        .cfg_pulse_len     (cfg_pulse_len),
`ifdef STIM_ASYM_PHASE_EN
        .cfg_pulse2_len    (cfg_pulse2_len),
        .cfg_magnitude2    (cfg_magnitude2),
`endif
        .cfg_inter_pulse   (cfg_inter_pulse),
        .cfg_inter_bipulse (cfg_inter_bipulse),
        .cfg_inter_train   (cfg_inter_train),
        .cfg_recovery      (cfg_recovery),
        .cfg_bipulses      (cfg_bipulses),
        .cfg_trains        (cfg_trains),
        .cfg_magnitude     (cfg_magnitude),
        .cfg_rising_first  (cfg_rising_first),
        .cfg_bipolar       (cfg_bipolar),
        .cfg_mask_pos      (cfg_mask_pos),
        .cfg_mask_neg      (cfg_mask_neg),
        .drv               (drv_if),
        .busy              (busy),
        .bipulse_idx       (bipulse_idx),
        .train_idx         (train_idx),
        .train_done        (train_done),
        .seq_done          (seq_done)
    );

    // One entry per sample_tick the sequencer is expected to consume.
    typedef struct {
        logic [CH-1:0] en;
        logic [CH-1:0] pol;
        logic [CH-1:0] rec;
        logic [MW-1:0] mag;
        logic [CW-1:0] bi;
        logic [CW-1:0] ti;
        int            ph;
        bit            tend;
    } frame_t;

    frame_t q[$];
    int checks = 0;
    int failures = 0;
    int td_seen = 0;

    int m_pl, m_pl2, m_ip, m_ibd, m_it, m_rec, m_nb, m_nt;
    logic [MW-1:0] m_mag, m_mag2;
    bit m_rf, m_bip;
    logic [CH-1:0] m_pos, m_neg;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t quiet(input int b, input int t);
        frame_t f;
        f = '{en: '0, pol: '0, rec: '0, mag: '0, bi: CW'(b), ti: CW'(t),
              ph: 0, tend: 1'b0};
        return f;
    endfunction

    function automatic void push_n(input frame_t f, input int n);
        for (int k = 0; k < n; k++) q.push_back(f);
    endfunction

    function automatic void build(input int nt);
        int pl, pl2, nb;
        logic [CH-1:0] drvm, p1;
        logic [MW-1:0] mg2;
        frame_t f;
        pl  = (m_pl == 0) ? 1 : m_pl;
        nb  = (m_nb == 0) ? 1 : m_nb;
        pl2 = pl;
        mg2 = m_mag;
`ifdef STIM_ASYM_PHASE_EN
        pl2 = (m_pl2 == 0) ? 1 : m_pl2;
        mg2 = m_mag2;
`endif
        drvm = '0;
        p1 = '0;
        for (int c = 0; c < CH; c++) begin
            if (m_pos[c]) begin
                drvm[c] = 1'b1;
                p1[c] = m_rf;
            end else if (m_bip && m_neg[c]) begin
                drvm[c] = 1'b1;
                p1[c] = !m_rf;
            end
        end
        q.delete();
        for (int t = 0; t < nt; t++) begin
            for (int b = 0; b < nb; b++) begin
                f = '{en: drvm, pol: p1, rec: '0, mag: m_mag, bi: CW'(b),
                      ti: CW'(t), ph: 1, tend: 1'b0};
                push_n(f, pl);
                push_n(quiet(b, t), m_ip);
                f = '{en: drvm, pol: drvm & ~p1, rec: '0, mag: mg2,
                      bi: CW'(b), ti: CW'(t), ph: 2, tend: 1'b0};
                push_n(f, pl2);
                if (b < nb - 1) push_n(quiet(b, t), m_ibd);
            end
            f = quiet(nb - 1, t);
            f.rec = drvm;
            push_n(f, m_rec);
            q[q.size() - 1].tend = 1'b1;
            if (t < nt - 1) push_n(quiet(nb - 1, t), m_it);
        end
    endfunction

    function automatic int find(input int t, input int b, input int ph);
        foreach (q[k])
            if (q[k].ti == CW'(t) && q[k].bi == CW'(b) && q[k].ph == ph)
                return k;
        return -1;
    endfunction

    task automatic set_cfg();
        cfg_pulse_len     = CW'(m_pl);
        cfg_inter_pulse   = CW'(m_ip);
        cfg_inter_bipulse = CW'(m_ibd);
        cfg_inter_train   = CW'(m_it);
        cfg_recovery      = CW'(m_rec);
        cfg_bipulses      = CW'(m_nb);
        cfg_trains        = CW'(m_nt);
        cfg_magnitude     = m_mag;
        cfg_rising_first  = m_rf;
        cfg_bipolar       = m_bip;
        cfg_mask_pos      = m_pos;
        cfg_mask_neg      = m_neg;
`ifdef STIM_ASYM_PHASE_EN
        cfg_pulse2_len    = CW'(m_pl2);
        cfg_magnitude2    = m_mag2;
`endif
    endtask

    task automatic scramble();
        cfg_pulse_len     = CW'($urandom);
        cfg_inter_pulse   = CW'($urandom);
        cfg_inter_bipulse = CW'($urandom);
        cfg_inter_train   = CW'($urandom);
        cfg_recovery      = CW'($urandom);
        cfg_bipulses      = CW'($urandom);
        cfg_trains        = CW'($urandom);
        cfg_magnitude     = MW'($urandom);
        cfg_rising_first  = ~m_rf;
        cfg_bipolar       = ~m_bip;
        cfg_mask_pos      = CH'($urandom);
        cfg_mask_neg      = CH'($urandom);
    endtask

    task automatic randomize_cfg();
        m_pl   = $urandom_range(0, 2);
        m_pl2  = $urandom_range(0, 3);
        m_ip   = $urandom_range(0, 2);
        m_ibd  = $urandom_range(0, 2);
        m_it   = $urandom_range(0, 3);
        m_rec  = $urandom_range(0, 3);
        m_nb   = $urandom_range(0, 3);
        m_nt   = $urandom_range(0, 3);
        m_mag  = MW'($urandom);
        m_mag2 = MW'($urandom);
        m_rf   = 1'($urandom);
        m_bip  = 1'($urandom);
        m_pos  = CH'($urandom);
        m_neg  = CH'($urandom);
    endtask

    task automatic cyc(input bit tk, input bit stp, input bit fs, input bit is);
        sample_tick    = tk;
        stop           = stp;
        finite_start   = fs;
        infinite_start = is;
        @(negedge clk);
        sample_tick    = 1'b0;
        stop           = 1'b0;
        finite_start   = 1'b0;
        infinite_start = 1'b0;
    endtask

    task automatic pulses(input bit td_exp, input bit sd_exp);
        if (train_done === 1'b1) td_seen++;
        chk("train_done", 64'(train_done), 64'(td_exp));
        chk("seq_done", 64'(seq_done), 64'(sd_exp));
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".en"}, 64'(drv_if.stim_en_mask), 64'(0));
        chk({tag, ".pol"}, 64'(drv_if.stim_pol_mask), 64'(0));
        chk({tag, ".mag"}, 64'(drv_if.stim_magnitude), 64'(0));
        chk({tag, ".rec"}, 64'(drv_if.recovery_en), 64'(0));
    endtask

    task automatic check_frame(input frame_t f);
        chk("busy", 64'(busy), 64'(1));
        chk("en", 64'(drv_if.stim_en_mask), 64'(f.en));
        chk("pol", 64'(drv_if.stim_pol_mask & drv_if.stim_en_mask), 64'(f.pol));
        chk("mag", 64'(drv_if.stim_magnitude), 64'(f.mag));
        chk("rec_en", 64'(drv_if.recovery_en), 64'(f.rec));
        chk("bipulse_idx", 64'(bipulse_idx), 64'(f.bi));
        chk("train_idx", 64'(train_idx), 64'(f.ti));
    endtask

    task automatic start(input bit fs, input bit is);
        set_cfg();
        cyc(1'b0, 1'b0, fs, is);
        scramble();
        chk("start_busy", 64'(busy), 64'(1));
    endtask

    task automatic play(input int stop_at, input int busy_at, input int rst_at);
        int n_td;
        int last;
        n_td = 0;
        last = q.size() - 1;
        td_seen = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    cyc(1'b0, 1'b0, 1'b0, 1'b0);
                    pulses(1'b0, 1'b0);
                end
            end
            if (i == stop_at) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0);
                pulses(1'b0, 1'b0);
            end
            if (i == busy_at) begin
                cyc(1'b0, 1'b0, 1'b1, 1'b0);
                pulses(1'b0, 1'b0);
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
                pulses(1'b0, 1'b0);
            end
            if (i == rst_at) begin
                rst = 1'b1;
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                rst = 1'b0;
                idle_outputs("rst_mid");
                chk("rst_mid.bi", 64'(bipulse_idx), 64'(0));
                chk("rst_mid.ti", 64'(train_idx), 64'(0));
                chk("rst_mid.td", 64'(train_done), 64'(0));
                return;
            end
            check_frame(q[i]);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            pulses(q[i].tend, i == last);
            if (q[i].tend) n_td++;
        end
        idle_outputs("end");
        chk("td_count", 64'(td_seen), 64'(n_td));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        pulses(1'b0, 1'b0);
    endtask

    task automatic plan_a();
        m_pl = 1; m_pl2 = 1; m_ip = 3; m_ibd = 3; m_it = 11;
        m_nb = 4; m_nt = 4; m_rec = 8;
        m_mag = 8'h5A; m_mag2 = 8'h5A; m_rf = 1'b1; m_bip = 1'b0;
        m_pos = 16'h00F0; m_neg = 16'h0F00;
    endtask

    initial begin
        logic [CW-1:0] hold_bi, hold_ti;
        int s;

        repeat (3) @(negedge clk);
        idle_outputs("reset");
        chk("reset.bi", 64'(bipulse_idx), 64'(0));
        chk("reset.ti", 64'(train_idx), 64'(0));
        chk("reset.td", 64'(train_done), 64'(0));
        chk("reset.sd", 64'(seq_done), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // finite run from the plan, with starts injected while busy
        plan_a();
        build(4);
        start(1'b1, 1'b0);
        play(-1, 40, -1);

        // polarity: ch7 positive group, ch15 negative group
        m_pl = 2; m_pl2 = 2; m_ip = 1; m_ibd = 1; m_it = 2;
        m_nb = 2; m_nt = 1; m_rec = 3;
        m_mag = 8'h33; m_mag2 = 8'h33; m_rf = 1'b1; m_bip = 1'b1;
        m_pos = 16'h0080; m_neg = 16'h8000;
        build(1);
        start(1'b1, 1'b0);
        play(-1, -1, -1);

        // infinite run, graceful stop in bipulse 1 of train 2
        m_pl = 1; m_pl2 = 1; m_ip = 2; m_ibd = 1; m_it = 2;
        m_nb = 3; m_nt = 1; m_rec = 2;
        m_mag = 8'hC3; m_mag2 = 8'hC3; m_rf = 1'b0; m_bip = 1'b1;
        m_pos = 16'h0003; m_neg = 16'h0006;
        build(3);
        s = find(2, 1, 1) + 1;
        start(1'b0, 1'b1);
        play(s, -1, -1);

        // infinite restart begins again at train 0
        build(1);
        start(1'b0, 1'b1);
        play(1, -1, -1);

        // zero gaps: back-to-back phases
        m_pl = 2; m_pl2 = 2; m_ip = 0; m_ibd = 0; m_it = 0;
        m_nb = 3; m_nt = 2; m_rec = 4;
        m_mag = 8'h11; m_mag2 = 8'h11; m_rf = 1'b1; m_bip = 1'b0;
        m_pos = 16'h1234; m_neg = 16'h4321;
        build(2);
        start(1'b1, 1'b0);
        play(-1, -1, -1);

        // start together with stop in IDLE does nothing
        hold_bi = q[q.size() - 1].bi;
        hold_ti = q[q.size() - 1].ti;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle_outputs("start_stop");
        chk("start_stop.bi", 64'(bipulse_idx), 64'(hold_bi));
        chk("start_stop.ti", 64'(train_idx), 64'(hold_ti));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_stop.busy2", 64'(busy), 64'(0));

        // zero recovery as well
        m_rec = 0; m_it = 1;
        build(2);
        start(1'b1, 1'b0);
        play(-1, -1, -1);

        // reset during PH2, then the plan run again
        plan_a();
        build(4);
        s = find(0, 1, 2);
        start(1'b1, 1'b0);
        play(-1, -1, s);
        plan_a();
        build(4);
        start(1'b1, 1'b0);
        play(-1, -1, -1);

        // randomized finite runs; both starts at once means finite
        for (int r = 0; r < 6; r++) begin
            randomize_cfg();
`ifndef STIM_ASYM_PHASE_EN
            m_pl2 = m_pl;
            m_mag2 = m_mag;
`endif
            build((m_nt == 0) ? 1 : m_nt);
            start(1'b1, 1'($urandom));
            play(-1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
